// File: rtl/six_bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor: z = x + ~y + 1, one bit per clock, LSB first,
// with a start/busy/done handshake and borrow/overflow/zero/negative status flags.
module six_bit_serial_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             x_msb, y_msb;

  logic             s, c_nxt, last;
  logic [WIDTH-1:0] z_nxt;

  // Single full-adder slice; B already holds ~y and carry starts at 1.
  assign s     = a[0] ^ b[0] ^ carry;
  assign c_nxt = (a[0] & b[0]) | (a[0] & carry) | (b[0] & carry);
  assign z_nxt = {s, z[WIDTH-1:1]};
  assign last  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a        <= '0;
      b        <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      x_msb    <= 1'b0;
      y_msb    <= 1'b0;
      z        <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a        <= x;
            b        <= ~y;
            x_msb    <= x[WIDTH-1];
            y_msb    <= y[WIDTH-1];
            carry    <= 1'b1;
            cnt      <= '0;
            z        <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
          end
        end
        SHIFT: begin
          a     <= {1'b0, a[WIDTH-1:1]};
          b     <= {1'b0, b[WIDTH-1:1]};
          carry <= c_nxt;
          cnt   <= cnt + 1'b1;
          z     <= z_nxt;
          // On the last bit s is the result MSB and c_nxt the final carry out.
          if (last) begin
            borrow   <= ~c_nxt;
            overflow <= (x_msb != y_msb) && (s != x_msb);
            zero     <= (z_nxt == '0);
            negative <= s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_six_bit_serial_subtractor.sv
// Directed and exhaustive checks of the serial subtractor against an arithmetic
// reference model, plus hand-computed literal results.
module tb_six_bit_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] x = '0;
  logic [5:0] y = '0;
  logic       busy, done;
  logic [5:0] z;
  logic       borrow, overflow, zero, negative;

  int n_cmp  = 0;
  int n_fail = 0;

  // {z, borrow, overflow, zero, negative}
  logic [9:0] exp_q[$];

  six_bit_serial_subtractor dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .z(z), .borrow(borrow),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] ref_model(input logic [5:0] xv, input logic [5:0] yv);
    int sx, sy, r;
    logic [5:0] d;
    logic bo, ov;
    sx = $signed(xv);
    sy = $signed(yv);
    r  = sx - sy;
    d  = xv - yv;
    bo = (int'(xv) < int'(yv));
    ov = (r > 31) || (r < -32);
    return {d, bo, ov, (d == 6'd0), d[5]};
  endfunction

  function automatic logic [9:0] dut_res();
    return {z, borrow, overflow, zero, negative};
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Compare process: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      chk("done_with_busy", int'(busy), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("result", int'(dut_res()), int'(e));
      end
    end
  end

  // Called at a negedge while the DUT is idle; returns at the negedge of the
  // first IDLE cycle after done.
  task automatic do_op(input logic [5:0] xv, input logic [5:0] yv, input bit poke);
    bit found;
    start = 1'b1;
    x = xv;
    y = yv;
    exp_q.push_back(ref_model(xv, yv));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x = 6'($urandom_range(0, 63));
    y = 6'($urandom_range(0, 63));
    found = 1'b0;
    for (int lat = 0; lat < 16 && !found; lat++) begin
      if (lat > 0) @(negedge clk);
      if (done) begin
        found = 1'b1;
        chk("latency", lat, 6);
      end else if (lat < 6) begin
        chk("busy_in_shift", int'(busy), 1);
      end
      if (poke && lat == 2) begin
        start = 1'b1;
        x = ~xv;
        y = yv ^ 6'h15;
      end
      if (poke && lat == 3) start = 1'b0;
    end
    if (!found) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("idle_after_done", int'({busy, done}), 0);
  endtask

  task automatic chk_lit(input string name, input logic [9:0] expv);
    chk(name, int'(dut_res()), int'(expv));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({busy, done, dut_res()}), 0);
    rst = 1'b0;
    @(negedge clk);

    do_op(6'd5, 6'd3, 1'b0);
    chk_lit("5-3", {6'b000010, 4'b0000});
    do_op(6'd3, 6'd5, 1'b0);
    chk_lit("3-5", {6'b111110, 4'b1001});
    do_op(6'b100000, 6'b000001, 1'b0);
    chk_lit("-32-1", {6'b011111, 4'b0100});
    do_op(6'd31, 6'b111111, 1'b0);
    chk_lit("31-(-1)", {6'b100000, 4'b1101});
    do_op(6'd7, 6'd7, 1'b0);
    chk_lit("7-7", {6'b000000, 4'b0010});
    do_op(6'd0, 6'd0, 1'b0);
    chk_lit("0-0", {6'b000000, 4'b0010});

    // Start pulsed mid-operation with other operands must be ignored.
    do_op(6'd20, 6'd9, 1'b1);
    chk_lit("ignored_start", {6'd11, 4'b0000});
    repeat (3) @(negedge clk);
    chk("hold_in_idle", int'(dut_res()), int'({6'd11, 4'b0000}));

    // Reset during the third SHIFT cycle: no done, everything cleared.
    start = 1'b1;
    x = 6'd5;
    y = 6'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_reset", int'({busy, done, dut_res()}), 0);
    repeat (8) @(negedge clk);
    chk("no_done_after_reset", int'({busy, done}), 0);
    do_op(6'd5, 6'd3, 1'b0);
    chk_lit("5-3_after_reset", {6'b000010, 4'b0000});

    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        do_op(6'(i), 6'(j), 1'b0);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
